// File: rtl/fp_vector_checker_pkg.sv
// Shared types for the floating-point vector checker: one-hot run states and
// the engine operation mode.
package fp_vector_checker_pkg;

  typedef enum logic [6:0] {
    ST_IDLE  = 7'b000_0001,
    ST_FETCH = 7'b000_0010,
    ST_CAPT  = 7'b000_0100,
    ST_DISP  = 7'b000_1000,
    ST_WAIT  = 7'b001_0000,
    ST_CMP   = 7'b010_0000,
    ST_FIN   = 7'b100_0000
  } state_t;

  typedef enum logic {
    MODE_SUB = 1'b0,
    MODE_ADD = 1'b1
  } mode_t;

endpackage

// File: rtl/fp_vector_checker_if.sv
// Start/done handshake between the vector checker (master) and the
// two-operand floating-point engine (slave).
interface fp_vector_checker_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned KEY_W  = 256
);
  logic              eng_start;
  logic [DATA_W-1:0] eng_a;
  logic [DATA_W-1:0] eng_b;
  logic              eng_zsign;
  logic              eng_mode;
  logic [KEY_W-1:0]  eng_key;
  logic              eng_done;
  logic [DATA_W-1:0] eng_result;

  modport master (
    output eng_start, eng_a, eng_b, eng_zsign, eng_mode, eng_key,
    input  eng_done, eng_result
  );

  modport slave (
    input  eng_start, eng_a, eng_b, eng_zsign, eng_mode, eng_key,
    output eng_done, eng_result
  );
endinterface

// File: rtl/fp_chk_watchdog.sv
// Loadable down-counter; expired is high once the count has reached zero.
module fp_chk_watchdog #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/fp_vector_checker.sv
// Streams (a, b, z) vectors from external ROMs through a floating-point engine
// and counts result mismatches, recording the first failing index.
module fp_vector_checker
  import fp_vector_checker_pkg::*;
#(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned N_VEC        = 22,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned FILTER_SIGNS = 1,
  parameter int unsigned KEY_W        = 256
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                ap_start,
  output logic                ap_done,
  output logic                ap_idle,
  output logic                ap_ready,
  output logic [31:0]         ap_return,
  input  logic                op_mode,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic                rom_ce,
  input  logic [DATA_W-1:0]   a_q,
  input  logic [DATA_W-1:0]   b_q,
  input  logic [DATA_W-1:0]   z_q,
  fp_vector_checker_if.master eng,
  input  logic [KEY_W-1:0]    working_key,
  output logic                fail_valid,
  output logic [ADDR_W-1:0]   fail_idx,
  output logic                timeout_err
);

  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state, nxt;
  mode_t              mode_r;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  a_r, b_r, z_r, res_r;
  logic [CNT_W-1:0]   cnt;
  logic               timed_out;
  logic               last, skip, mismatch, wd_expired;

  // idx carries one extra bit so N_VEC == 2**ADDR_W ends without wrapping
  assign last     = (idx == IDX_W'(N_VEC));
  assign skip     = (FILTER_SIGNS != 0) && (a_q[DATA_W-1] == b_q[DATA_W-1]);
  assign mismatch = timed_out || (res_r != z_r);

  fp_chk_watchdog #(.W(WD_W)) u_watchdog (
    .clk      (ap_clk),
    .rst      (ap_rst),
    .load     (state == ST_DISP),
    .load_val (WD_W'(TIMEOUT - 1)),
    .en       (state == ST_WAIT),
    .expired  (wd_expired)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (ap_start) nxt = ST_FETCH;
      ST_FETCH: nxt = last ? ST_FIN : ST_CAPT;
      ST_CAPT:  nxt = skip ? ST_FETCH : ST_DISP;
      ST_DISP:  nxt = ST_WAIT;
      ST_WAIT:  if (eng.eng_done || wd_expired) nxt = ST_CMP;
      ST_CMP:   nxt = ST_FETCH;
      ST_FIN:   nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ap_done       = (state == ST_FIN);
    ap_ready      = (state == ST_FIN);
    ap_idle       = (state == ST_IDLE) && !ap_start;
    rom_ce        = (state == ST_FETCH) && !last;
    rom_addr      = '0;
    if ((state == ST_FETCH) && !last) rom_addr = idx[ADDR_W-1:0];
    eng.eng_start = (state == ST_DISP);
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      mode_r      <= MODE_SUB;
      idx         <= '0;
      a_r         <= '0;
      b_r         <= '0;
      z_r         <= '0;
      res_r       <= '0;
      cnt         <= '0;
      timed_out   <= 1'b0;
      fail_valid  <= 1'b0;
      fail_idx    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ap_start) begin
            cnt         <= '0;
            fail_valid  <= 1'b0;
            fail_idx    <= '0;
            timeout_err <= 1'b0;
            mode_r      <= mode_t'(op_mode);
            idx         <= '0;
          end
        end
        ST_CAPT: begin
          a_r <= a_q;
          b_r <= b_q;
          z_r <= z_q;
          if (skip) idx <= idx + IDX_W'(1);
        end
        ST_DISP: timed_out <= 1'b0;
        ST_WAIT: begin
          // a done in the expiry cycle still wins over the timeout
          if (eng.eng_done) begin
            res_r <= eng.eng_result;
          end else if (wd_expired) begin
            timed_out   <= 1'b1;
            timeout_err <= 1'b1;
          end
        end
        ST_CMP: begin
          if (mismatch) begin
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_idx   <= idx[ADDR_W-1:0];
            end
          end
          idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign ap_return     = 32'(cnt);
  assign eng.eng_a     = a_r;
  assign eng.eng_b     = b_r;
  assign eng.eng_zsign = a_r[DATA_W-1];
  assign eng.eng_mode  = mode_r;
  assign eng.eng_key   = working_key;

endmodule

// File: tb/tb_fp_vector_checker.sv
// Directed bench: five checker configurations, each with its own ROM model and
// a mock engine (integer add/sub) with per-vector latency.
module tb_fp_vector_checker;

  localparam int unsigned NI = 5;
  // per-instance configuration, element 0 rightmost
  localparam logic [NI-1:0][7:0] P_NV = {8'd6, 8'd0, 8'd22, 8'd22, 8'd4};
  localparam logic [NI-1:0][7:0] P_FS = {8'd0, 8'd0, 8'd1, 8'd0, 8'd0};
  localparam logic [NI-1:0][7:0] P_TO = {8'd255, 8'd255, 8'd255, 8'd8, 8'd255};
  localparam logic [NI-1:0][7:0] P_CW = {8'd2, 8'd8, 8'd8, 8'd8, 8'd8};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_a  [NI];
  logic        mode_a   [NI];
  logic        inj_done [NI];
  logic        done_a   [NI];
  logic        idle_a   [NI];
  logic        ready_a  [NI];
  logic        fv_a     [NI];
  logic        te_a     [NI];
  logic        estart_a [NI];
  logic [31:0] ret_a    [NI];
  logic [4:0]  fidx_a   [NI];
  int unsigned nstart_a [NI];
  logic [255:0] key;

  logic [63:0] rom_a [NI][32];
  logic [63:0] rom_b [NI][32];
  logic [63:0] rom_z [NI][32];
  int unsigned lat_v [NI][32];

  for (genvar k = 0; k < NI; k++) begin : g
    fp_vector_checker_if #(.DATA_W(64), .KEY_W(256)) eif ();
    logic [4:0]  rom_addr, last_addr;
    logic        rom_ce, mdone;
    logic [63:0] a_q, b_q, z_q;
    int unsigned cdown, nstart;

    fp_vector_checker #(
      .DATA_W(64), .N_VEC(int'(P_NV[k])), .ADDR_W(5), .CNT_W(int'(P_CW[k])),
      .TIMEOUT(int'(P_TO[k])), .FILTER_SIGNS(int'(P_FS[k])), .KEY_W(256)
    ) dut (
      .ap_clk(clk), .ap_rst(rst), .ap_start(start_a[k]), .ap_done(done_a[k]),
      .ap_idle(idle_a[k]), .ap_ready(ready_a[k]), .ap_return(ret_a[k]),
      .op_mode(mode_a[k]), .rom_addr(rom_addr), .rom_ce(rom_ce),
      .a_q(a_q), .b_q(b_q), .z_q(z_q), .eng(eif), .working_key(key),
      .fail_valid(fv_a[k]), .fail_idx(fidx_a[k]), .timeout_err(te_a[k])
    );

    always_ff @(posedge clk) begin
      if (rom_ce) begin
        a_q       <= rom_a[k][rom_addr];
        b_q       <= rom_b[k][rom_addr];
        z_q       <= rom_z[k][rom_addr];
        last_addr <= rom_addr;
      end
    end

    // mock engine: done arrives lat_v cycles after the start pulse
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cdown <= 0; mdone <= 1'b0; nstart <= 0;
      end else if (eif.eng_start) begin
        nstart <= nstart + 1;
        cdown  <= lat_v[k][last_addr] - 1;
        mdone  <= (lat_v[k][last_addr] == 1);
      end else if (cdown != 0) begin
        cdown <= cdown - 1;
        mdone <= (cdown == 1);
      end else begin
        mdone <= 1'b0;
      end
    end

    assign eif.eng_done   = mdone | inj_done[k];
    assign eif.eng_result = eif.eng_mode ? eif.eng_a + eif.eng_b : eif.eng_a - eif.eng_b;
    assign estart_a[k]    = eif.eng_start;
    assign nstart_a[k]    = nstart;
  end

  typedef struct {
    int unsigned inst;
    logic        mode;
    logic        zmode;
    int unsigned lat;
    logic [31:0] badm;
    logic [31:0] sgn;
    int          hang;
    logic [31:0] e_ret;
    logic        e_fv;
    logic [4:0]  e_fidx;
    logic        e_te;
    int unsigned e_starts;
    int unsigned e_cyc;
  } rec_t;

  rec_t tv [9];
  rec_t rr;
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic fill(input int unsigned k, input logic zmode, input int unsigned lat,
                      input logic [31:0] badm, input logic [31:0] sgn, input int hang);
    for (int v = 0; v < 32; v++) begin
      logic [63:0] a, b, z;
      a = 64'h0123_4567_89AB_CDEF + 64'(v) * 64'd977;
      a[63] = 1'b0;
      b = 64'h0000_0000_0100_0000 + 64'(v) * 64'd31 + 64'd5;
      b[63] = sgn[v];
      z = zmode ? a + b : a - b;
      if (badm[v]) z[0] = ~z[0];
      rom_a[k][v] = a;
      rom_b[k][v] = b;
      rom_z[k][v] = z;
      lat_v[k][v] = (v == hang) ? 12 : lat;
    end
  endtask

  task automatic run_rec(input int id, input rec_t r);
    int unsigned k, s0, cyc;
    bit seen;
    k = r.inst;
    fill(k, r.zmode, r.lat, r.badm, r.sgn, r.hang);
    @(negedge clk);
    s0 = nstart_a[k];
    start_a[k] = 1'b1;
    mode_a[k]  = r.mode;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk($sformatf("r%0d_idle_busy", id), idle_a[k], 1'b0);
      // start held one extra cycle and mode flipped: both must be ignored
      if (cyc == 2) begin
        start_a[k] = 1'b0;
        mode_a[k]  = ~r.mode;
      end
      if (done_a[k]) seen = 1'b1;
    end
    chk($sformatf("r%0d_done_seen", id), seen, 1'b1);
    chk($sformatf("r%0d_cycles", id), cyc, r.e_cyc);
    chk($sformatf("r%0d_ready", id), ready_a[k], 1'b1);
    chk($sformatf("r%0d_ret", id), ret_a[k], r.e_ret);
    chk($sformatf("r%0d_fail_valid", id), fv_a[k], r.e_fv);
    chk($sformatf("r%0d_fail_idx", id), fidx_a[k], r.e_fidx);
    chk($sformatf("r%0d_timeout", id), te_a[k], r.e_te);
    chk($sformatf("r%0d_starts", id), nstart_a[k] - s0, r.e_starts);
    @(negedge clk);
    chk($sformatf("r%0d_done_pulse", id), done_a[k], 1'b0);
    chk($sformatf("r%0d_idle_after", id), idle_a[k], 1'b1);
    chk($sformatf("r%0d_ret_held", id), ret_a[k], r.e_ret);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int unsigned w, s0;
    for (int i = 0; i < int'(NI); i++) begin
      start_a[i] = 1'b0; mode_a[i] = 1'b0; inj_done[i] = 1'b0;
    end
    key = {64'hDEAD_BEEF_0000_1111, 64'h2222_3333_4444_5555,
           64'h6666_7777_8888_9999, 64'hAAAA_BBBB_CCCC_DDDD};

    //     inst mode zm lat badm          sgn       hang ret fv fidx te st cyc
    tv[0] = '{0, 1'b1, 1'b1, 3, 32'h0,        32'h0,  -1, 0, 1'b0, 5'd0,  1'b0, 4,  30};
    tv[1] = '{0, 1'b0, 1'b1, 1, 32'h0,        32'h0,  -1, 4, 1'b1, 5'd0,  1'b0, 4,  22};
    tv[2] = '{1, 1'b0, 1'b0, 2, 32'h0002_0008, 32'h0, -1, 2, 1'b1, 5'd3,  1'b0, 22, 134};
    tv[3] = '{1, 1'b0, 1'b0, 3, 32'h0,        32'h0,   2, 1, 1'b1, 5'd2,  1'b1, 22, 161};
    tv[4] = '{2, 1'b0, 1'b0, 3, 32'h003F_FFDE, 32'h21, -1, 0, 1'b0, 5'd0, 1'b0, 2,  56};
    tv[5] = '{2, 1'b0, 1'b0, 3, 32'h220,      32'h21, -1, 1, 1'b1, 5'd5,  1'b0, 2,  56};
    tv[6] = '{3, 1'b0, 1'b0, 1, 32'h0,        32'h0,  -1, 0, 1'b0, 5'd0,  1'b0, 0,  2};
    tv[7] = '{4, 1'b0, 1'b0, 1, 32'h3F,       32'h0,  -1, 3, 1'b1, 5'd0,  1'b0, 6,  32};
    tv[8] = '{1, 1'b0, 1'b0, 2, 32'h0,        32'h0,  -1, 0, 1'b0, 5'd0,  1'b0, 22, 134};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < int'(NI); i++) begin
      chk($sformatf("rst_ret%0d", i), ret_a[i], 32'd0);
      chk($sformatf("rst_done%0d", i), done_a[i], 1'b0);
      chk($sformatf("rst_fv%0d", i), fv_a[i], 1'b0);
      chk($sformatf("rst_te%0d", i), te_a[i], 1'b0);
      chk($sformatf("rst_estart%0d", i), estart_a[i], 1'b0);
      chk($sformatf("rst_idle%0d", i), idle_a[i], 1'b1);
    end
    rst = 1'b0;
    @(negedge clk);

    chk("key_lo", g[0].eif.eng_key[63:0], key[63:0]);
    chk("key_hi", g[0].eif.eng_key[255:192], key[255:192]);
    key[200] = ~key[200];
    #1;
    chk("key_follow", g[0].eif.eng_key[255:192], key[255:192]);

    for (int i = 0; i < 9; i++) begin
      run_rec(i, tv[i]);
      if (i == 3) begin
        // stray done while idle must not disturb the held results
        s0 = nstart_a[1];
        inj_done[1] = 1'b1;
        @(negedge clk);
        inj_done[1] = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_done_ret", ret_a[1], 32'd1);
        chk("idle_done_te", te_a[1], 1'b1);
        chk("idle_done_fidx", fidx_a[1], 5'd2);
        chk("idle_done_idle", idle_a[1], 1'b1);
        chk("idle_done_starts", nstart_a[1] - s0, 0);
      end
    end

    // abort a run in WAIT: two mismatches already counted at that point
    fill(1, 1'b0, 3, 32'h3, 32'h0, -1);
    @(negedge clk);
    s0 = nstart_a[1];
    start_a[1] = 1'b1;
    mode_a[1]  = 1'b0;
    @(negedge clk);
    start_a[1] = 1'b0;
    w = 0;
    while (nstart_a[1] != s0 + 6 && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("abort_reach_wait", (w < 500), 1'b1);
    chk("abort_pre_ret", ret_a[1], 32'd2);
    rst = 1'b1;
    #1;
    chk("abort_estart", estart_a[1], 1'b0);
    chk("abort_ret", ret_a[1], 32'd0);
    chk("abort_fv", fv_a[1], 1'b0);
    chk("abort_idle", idle_a[1], 1'b1);
    repeat (2) begin
      @(negedge clk);
      chk("abort_estart_hold", estart_a[1], 1'b0);
    end
    rst = 1'b0;
    rr = '{1, 1'b0, 1'b0, 3, 32'h3, 32'h0, -1, 2, 1'b1, 5'd0, 1'b0, 22, 156};
    run_rec(9, rr);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
